// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register: hold, shifts, rotates, load, clear,
// plus a counted burst-shift engine reporting busy/done.
module universal_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             serial_in_l,
  input  logic             serial_in_r,
  input  logic [WIDTH-1:0] load_data,
  input  logic             burst_start,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] q,
  output logic             serial_out_l,
  output logic             serial_out_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_SHL  = 3'b001,
    M_SHR  = 3'b010,
    M_SAR  = 3'b011,
    M_ROL  = 3'b100,
    M_ROR  = 3'b101,
    M_LOAD = 3'b110,
    M_CLR  = 3'b111
  } op_e;

  typedef enum logic {IDLE, BURST} state_e;

  state_e           state, state_nx;
  op_e              op, op_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] q_nx;
  logic             busy_nx, done_nx;
  logic             start_ok;

  function automatic logic [WIDTH-1:0] apply_op(
    input op_e              o,
    input logic [WIDTH-1:0] v,
    input logic             sl,
    input logic             sr,
    input logic [WIDTH-1:0] ld
  );
    logic [WIDTH-1:0] r;
    r = v;
    case (o)
      M_SHL:   r = {v[WIDTH-2:0], sl};
      M_SHR:   r = {sr, v[WIDTH-1:1]};
      M_SAR:   r = {v[WIDTH-1], v[WIDTH-1:1]};
      M_ROL:   r = {v[WIDTH-2:0], v[WIDTH-1]};
      M_ROR:   r = {v[0], v[WIDTH-1:1]};
      M_LOAD:  r = ld;
      M_CLR:   r = '0;
      default: r = v;
    endcase
    return r;
  endfunction

  // Only shift/rotate modes with a non-zero length may start a burst.
  assign start_ok = burst_start && (burst_len != '0) &&
                    (op_e'(mode) inside {M_SHL, M_SHR, M_SAR, M_ROL, M_ROR});

  always_comb begin
    state_nx = state;
    op_nx    = op;
    cnt_nx   = cnt;
    q_nx     = q;
    busy_nx  = busy;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_nx = BURST;
          op_nx    = op_e'(mode);
          cnt_nx   = burst_len;
          busy_nx  = 1'b1;
        end else if (en) begin
          q_nx = apply_op(op_e'(mode), q, serial_in_l, serial_in_r, load_data);
        end
      end
      BURST: begin
        q_nx   = apply_op(op, q, serial_in_l, serial_in_r, load_data);
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op    <= M_HOLD;
      cnt   <= '0;
      q     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      op    <= op_nx;
      cnt   <= cnt_nx;
      q     <= q_nx;
      busy  <= busy_nx;
      done  <= done_nx;
    end
  end

  assign serial_out_l = q[WIDTH-1];
  assign serial_out_r = q[0];

endmodule
